// File: rtl/arith_pkg.sv
// Shared arithmetic-family definitions: FSM state encoding and WIDTH legality bounds.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arith_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_RUN  = S_RUN,
    ST_DONE = S_DONE
  } state_t;

  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/add_1bit.sv
// Combinational 1-bit full adder; the only arithmetic cell of the serial datapath.
// Latency: zero (purely combinational).
// Backpressure: none.
// Ports: a_in, b_in, carry_in -> sum_out, carry_out.
module add_1bit (
  input  logic a_in,
  input  logic b_in,
  input  logic carry_in,
  output logic sum_out,
  output logic carry_out
);

  assign sum_out   = a_in ^ b_in ^ carry_in;
  assign carry_out = (a_in & b_in) | (a_in & carry_in) | (b_in & carry_in);

endmodule

// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder: LSB-first through one full-adder cell, registered sum/carry.
// Latency: done_out rises WIDTH edges after the accepting edge; one add per WIDTH+1 cycles.
// Backpressure: start_in is ignored while busy_out=1; accepted in IDLE or in the DONE cycle.
// Ports: clk_in/rst_in (async, active-high); start_in, a_in, b_in, carry_in in;
//        busy_out, done_out, sum_out, carry_out out (sum/carry held until next completion).
module serial_adder_nbit
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             carry_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder_nbit: WIDTH out of range");
  end

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             last;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic [WIDTH-1:0] s_sh_nxt;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_c;

  add_1bit u_fa (
    .a_in      (a_sh[0]),
    .b_in      (b_sh[0]),
    .carry_in  (c),
    .sum_out   (fa_s),
    .carry_out (fa_c)
  );

  // Sum bits enter at the MSB and walk down, so after WIDTH shifts bit 0 sits at bit 0.
  if (WIDTH == 1) begin : g_sum_w1
    assign s_sh_nxt = fa_s;
  end else begin : g_sum_wn
    assign s_sh_nxt = {fa_s, s_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    last      = (state == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));
    case (state)
      ST_IDLE: begin
        if (start_in) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start in the DONE cycle is taken immediately for back-to-back operation.
        if (start_in) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_sh      <= '0;
      b_sh      <= '0;
      s_sh      <= '0;
      c         <= 1'b0;
      cnt       <= '0;
      done_out  <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      done_out <= last;
      if (load) begin
        a_sh <= a_in;
        b_sh <= b_in;
        c    <= carry_in;
        cnt  <= '0;
      end else if (state == ST_RUN) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        s_sh <= s_sh_nxt;
        c    <= fa_c;
        cnt  <= cnt + CNT_W'(1);
      end
      // Outputs only move on the completion edge, so partial sums are never visible.
      if (last) begin
        sum_out   <= s_sh_nxt;
        carry_out <= fa_c;
      end
    end
  end

  assign busy_out = (state == ST_RUN);

endmodule

// File: tb/tb_serial_adder_nbit.sv
module tb_serial_adder_nbit;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  logic start1, a1, b1, cin1, busy1, done1, sum1, cout1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
  } vec_t;
  vec_t vecs[9];

  logic [W-1:0] last_s;
  logic         last_c;

  serial_adder_nbit #(.WIDTH(W)) dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .a_in(a), .b_in(b), .carry_in(cin),
    .busy_out(busy), .done_out(done), .sum_out(sum), .carry_out(cout)
  );

  serial_adder_nbit #(.WIDTH(1)) dut1 (
    .clk_in(clk), .rst_in(rst), .start_in(start1), .a_in(a1), .b_in(b1), .carry_in(cin1),
    .busy_out(busy1), .done_out(done1), .sum_out(sum1), .carry_out(cout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse pops one expectation and checks value and cycle.
  always @(negedge clk) begin
    if (rst) begin
      last_s = '0;
      last_c = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("carry", 32'(cout), 32'(e.c));
        chk("done_cycle", cyc, e.due);
        chk("busy_at_done", 32'(busy), 0);
      end
      last_s = sum;
      last_c = cout;
    end else begin
      chk("sum_hold", {23'd0, cout, sum}, {23'd0, last_c, last_s});
    end
  end

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=0 expected=1 (cycle %0d)", cyc);
    end
  endtask

  // Called just after a rising edge; leaves just after a rising edge in IDLE.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W-1:0] vs, input logic vco);
    exp_t e;
    start = 1'b1; a = va; b = vb; cin = vc;
    e.s = vs; e.c = vco; e.due = cyc + 1 + W;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    @(negedge clk);
    chk("busy_run", 32'(busy), 1);
    wait_done();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;

    vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[7] = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};
    vecs[8] = '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_carry", 32'(cout), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c);
    end

    // Start while busy: the second request at RUN cycle 3 must be ignored.
    begin
      exp_t e;
      start = 1'b1; a = 8'h10; b = 8'h01; cin = 1'b0;
      e.s = 8'h11; e.c = 1'b0; e.due = cyc + 1 + W;
      sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; a = 8'h77; b = 8'h77;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done();
      repeat (12) @(posedge clk);
      #1;
    end

    // Back-to-back: start held through the DONE cycle.
    begin
      exp_t e;
      start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
      e.s = 8'h03; e.c = 1'b0; e.due = cyc + 1 + W;
      sb.push_back(e);
      e.due = cyc + 2 + 2 * W;
      sb.push_back(e);
      wait_done();
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("b2b_busy", 32'(busy), 1);
      wait_done();
      @(posedge clk); #1;
    end

    // Reset mid-run: immediate zeros, no completion afterwards.
    start = 1'b1; a = 8'h44; b = 8'h11; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_sum", 32'(sum), 0);
    chk("arst_carry", 32'(cout), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("arst_idle", 32'(busy), 0);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // WIDTH=1 instance: completes on the first RUN edge.
    for (int i = 0; i < 4; i++) begin
      logic [3:0] v;
      logic [1:0] r;
      v = 4'(i);
      case (i)
        0: begin a1 = 1; b1 = 1; cin1 = 1; end
        1: begin a1 = 1; b1 = 0; cin1 = 0; end
        2: begin a1 = 0; b1 = 0; cin1 = 1; end
        default: begin a1 = 1; b1 = 1; cin1 = 0; end
      endcase
      r = 2'(a1) + 2'(b1) + 2'(cin1);
      start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      @(negedge clk);
      chk($sformatf("w1_busy_%0d", v), 32'(busy1), 1);
      chk($sformatf("w1_early_done_%0d", v), 32'(done1), 0);
      @(negedge clk);
      chk($sformatf("w1_done_%0d", v), 32'(done1), 1);
      chk($sformatf("w1_sum_%0d", v), 32'(sum1), 32'(r[0]));
      chk($sformatf("w1_carry_%0d", v), 32'(cout1), 32'(r[1]));
      chk($sformatf("w1_busy_after_%0d", v), 32'(busy1), 0);
      @(posedge clk); #1;
    end

    repeat (4) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
